instr_encoder: RTL and testbench

Field-to-word RV32I instruction encoder, the inverse of the control/format decode path. Accepts decoded instruction fields plus a one-hot format and packs them into 32-bit instruction words. Checks opcode/format/immediate legality and buffers legal words in a small FIFO. Words stream out with auto-incrementing instruction-memory addresses, so the block can serve as a test-program loader or self-check source for the datapath.

---
 rtl/instr_encoder.sv | 165 ++++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with legality checks and a small output FIFO.
// Optional: define INSTR_ENC_X0_NOP_EN to emit rd=x0 ALU/LUI requests as canonical NOP.
module instr_encoder #(
  parameter int                FIFO_DEPTH = 2,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [5:0]        i_format,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  input  logic              i_clr_err,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [15:0]       o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BRCH = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIP = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;

  logic        fmt_onehot, op_ok, imm_ok, shift_ok, legal;
  logic        sext12, sext13, sext21;
  logic        accept, push, pop;
  logic [31:0] word;

  always_comb begin
    fmt_onehot = (i_format != '0) && ((i_format & (i_format - 6'd1)) == '0);
    sext12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    sext13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    sext21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);
    shift_ok = 1'b1;
    if (i_opcode == OP_IMM) begin
      if (i_funct3 == 3'b001) shift_ok = (i_imm[11:5] == 7'b0000000);
      if (i_funct3 == 3'b101) shift_ok = (i_imm[11:5] == 7'b0000000) || (i_imm[11:5] == 7'b0100000);
    end
    op_ok  = 1'b0;
    imm_ok = 1'b0;
    word   = '0;
    case (i_format)
      FMT_R: begin
        op_ok  = (i_opcode == OP_REG);
        imm_ok = 1'b1;
        word   = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_I: begin
        op_ok  = (i_opcode == OP_IMM) || (i_opcode == OP_LOAD) || (i_opcode == OP_JALR);
        imm_ok = sext12 && shift_ok;
        word   = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_S: begin
        op_ok  = (i_opcode == OP_STOR);
        imm_ok = sext12;
        word   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      FMT_B: begin
        op_ok  = (i_opcode == OP_BRCH);
        imm_ok = sext13 && !i_imm[0];
        word   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
      end
      FMT_U: begin
        op_ok  = (i_opcode == OP_LUI) || (i_opcode == OP_AUIP);
        imm_ok = (i_imm[11:0] == '0);
        word   = {i_imm[31:12], i_rd, i_opcode};
      end
      FMT_J: begin
        op_ok  = (i_opcode == OP_JAL);
        imm_ok = sext21 && !i_imm[0];
        word   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      default: ;
    endcase
    legal = fmt_onehot && op_ok && imm_ok;
`ifdef INSTR_ENC_X0_NOP_EN
    // Writes to x0 are architecturally dead; collapse them to the canonical NOP.
    if ((i_rd == 5'd0) && ((i_opcode == OP_IMM) || (i_opcode == OP_REG) || (i_opcode == OP_LUI)))
      word = 32'h0000_0013;
`endif
  end

  assign o_ready = (cnt_q != FULL_CNT);
  assign o_valid = (cnt_q != '0);
  assign o_instr = mem_q[rd_ptr_q];
  assign o_addr  = addr_q;
  assign o_err   = err_q;
  assign o_count = count_q;

  assign accept = i_valid && o_ready;
  assign push   = accept && legal;
  assign pop    = o_valid && i_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
    addr_d  = pop ? addr_q + ADDR_W'(4) : addr_q;
    count_d = (pop && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
    // A new illegal request wins over a simultaneous clear.
    if (accept && !legal) err_d = 1'b1;
    else if (i_clr_err)   err_d = 1'b0;
    else                  err_d = err_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_rst) mem_q[wr_ptr_q] <= word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps plus random requests against a spec-level model.
module tb_instr_encoder;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_valid = 1'b0, i_clr_err = 1'b0, i_ready = 1'b1;
  logic [5:0]  i_format = '0;
  logic [6:0]  i_opcode = '0, i_funct7 = '0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_imm = '0;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_instr, o_addr;
  logic [15:0] o_count;

  int n_vec = 0, n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_addr = '0;
  int          m_count = 0;
  bit          m_err = 0, mdl_on = 0, last_acc = 0;

  instr_encoder dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_format(i_format), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1),
    .i_rs2(i_rs2), .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .i_clr_err(i_clr_err), .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_addr(o_addr), .o_err(o_err), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bits(logic [31:0] v, int hi, int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic bit m_legal(logic [5:0] f, logic [6:0] op, logic [2:0] f3, logic [31:0] imm);
    int s;
    bit ok;
    s = signed'(imm);
    if ($countones(f) != 1) return 0;
    case (f)
      6'd1:  ok = (op == 7'h33);
      6'd2:  ok = (op == 7'h13 || op == 7'h03 || op == 7'h67) && s >= -2048 && s <= 2047;
      6'd4:  ok = (op == 7'h23) && s >= -2048 && s <= 2047;
      6'd8:  ok = (op == 7'h63) && s >= -4096 && s <= 4095 && (s % 2 == 0);
      6'd16: ok = (op == 7'h37 || op == 7'h17) && (imm % 4096 == 0);
      default: ok = (op == 7'h6F) && s >= -(1 << 20) && s < (1 << 20) && (s % 2 == 0);
    endcase
    if (f == 6'd2 && op == 7'h13 && f3 == 3'd1 && bits(imm, 11, 5) != 0) ok = 0;
    if (f == 6'd2 && op == 7'h13 && f3 == 3'd5 && bits(imm, 11, 5) != 0 && bits(imm, 11, 5) != 32) ok = 0;
    return ok;
  endfunction

  function automatic logic [31:0] m_encode(logic [5:0] f, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                           logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
    logic [31:0] regs;
    regs = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
`ifdef INSTR_ENC_X0_NOP_EN
    if (rd == 0 && (op == 7'h13 || op == 7'h33 || op == 7'h37)) return 32'h13;
`endif
    case (f)
      6'd1:  return (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
      6'd2:  return (bits(imm, 11, 0) << 20) | regs | (32'(rd) << 7);
      6'd4:  return (bits(imm, 11, 5) << 25) | (32'(rs2) << 20) | regs | (bits(imm, 4, 0) << 7);
      6'd8:  return (bits(imm, 12, 12) << 31) | (bits(imm, 10, 5) << 25) | (32'(rs2) << 20) | regs
                    | (bits(imm, 4, 1) << 8) | (bits(imm, 11, 11) << 7);
      6'd16: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      default: return (bits(imm, 20, 20) << 31) | (bits(imm, 10, 1) << 21) | (bits(imm, 11, 11) << 20)
                    | (bits(imm, 19, 12) << 12) | (32'(rd) << 7) | 32'(op);
    endcase
  endfunction

  // One clock: check outputs against the model, advance the model with the applied inputs.
  task automatic cyc();
    bit acc, lgl, pp;
    @(negedge clk);
    if (mdl_on) begin
      chk("o_ready", 32'(o_ready), 32'(exp_q.size() < DEPTH));
      chk("o_valid", 32'(o_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("o_instr", o_instr, exp_q[0]);
        chk("o_addr", o_addr, m_addr);
      end
      chk("o_err", 32'(o_err), 32'(m_err));
      chk("o_count", 32'(o_count), 32'(m_count));
    end
    last_acc = 0;
    if (i_rst) begin
      exp_q.delete();
      m_addr = 0; m_count = 0; m_err = 0; mdl_on = 1;
    end else if (mdl_on) begin
      acc = i_valid && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() > 0) && i_ready;
      lgl = m_legal(i_format, i_opcode, i_funct3, i_imm);
      last_acc = acc;
      if (pp) begin
        void'(exp_q.pop_front());
        m_addr += 4;
        if (m_count < 65535) m_count++;
      end
      if (acc && lgl) exp_q.push_back(m_encode(i_format, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm));
      if (acc && !lgl) m_err = 1;
      else if (i_clr_err) m_err = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic [5:0] f, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
    i_format = f; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm; i_valid = 1'b1;
  endtask

  task automatic check_head(string tag, logic [31:0] w, logic [31:0] a);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_instr"}, o_instr, w);
    chk({tag, "_addr"}, o_addr, a);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0;
    cyc();
    i_rst = 1'b0;
  endtask

  task automatic rand_req();
    int idx;
    logic [5:0] f;
    logic [6:0] op;
    logic [31:0] imm;
    idx = $urandom_range(0, 5);
    f = 6'(1 << idx);
    if ($urandom_range(0, 9) == 0) f = 6'($urandom);
    case (idx)
      0: op = 7'h33;
      1: case ($urandom_range(0, 2)) 0: op = 7'h13; 1: op = 7'h03; default: op = 7'h67; endcase
      2: op = 7'h23;
      3: op = 7'h63;
      4: op = $urandom_range(0, 1) ? 7'h37 : 7'h17;
      default: op = 7'h6F;
    endcase
    if ($urandom_range(0, 9) == 0) op = 7'($urandom);
    case ($urandom_range(0, 4))
      0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFFF000;
      3: imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
      default: imm = ($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 127)) : 32'h20 * 32'($urandom_range(0, 1))) << 5
                     | 32'($urandom_range(0, 31));
    endcase
    set_req(f, op, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), imm);
    i_valid = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);

    // addi x1,x0,5 then add x3,x1,x2
    i_ready = 1'b1;
    set_req(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    cyc();
    check_head("addi", 32'h00500093, 32'd0);
    set_req(6'b000001, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    cyc();
    i_valid = 1'b0;
    check_head("add", 32'h002081B3, 32'd4);
    cyc();

    // sw / beq / lui from a fresh address
    do_reset();
    set_req(6'b000100, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    cyc();
    check_head("sw", 32'h0020A423, 32'd0);
    set_req(6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    cyc();
    check_head("beq", 32'hFE208EE3, 32'd4);
    set_req(6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    cyc();
    check_head("lui", 32'h123452B7, 32'd8);

    // misaligned branch is consumed and flagged
    set_req(6'b001000, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    cyc();
    i_valid = 1'b0;
    chk("ill_err", 32'(o_err), 32'd1);
    chk("ill_valid", 32'(o_valid), 32'd0);
    chk("ill_count", 32'(o_count), 32'd3);
    i_clr_err = 1'b1;
    cyc();
    i_clr_err = 1'b0;
    chk("clr_err", 32'(o_err), 32'd0);

    // backpressure fills the FIFO, third request waits
    do_reset();
    i_ready = 1'b0;
    set_req(6'b000010, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    cyc();
    set_req(6'b000010, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    cyc();
    chk("bp_full", 32'(o_ready), 32'd0);
    set_req(6'b000010, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    cyc();
    chk("bp_hold", 32'(o_ready), 32'd0);
    check_head("bp_first", 32'h00100093, 32'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (last_acc) break;
    end
    chk("bp_third_taken", 32'(last_acc), 32'd1);
    i_valid = 1'b0;
    repeat (4) cyc();

    // reset with buffered words and a pending push
    i_ready = 1'b0;
    set_req(6'b000010, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    cyc();
    cyc();
    set_req(6'b000010, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    i_rst = 1'b1; i_ready = 1'b1;
    cyc();
    i_rst = 1'b0; i_valid = 1'b0;
    chk("rst2_valid", 32'(o_valid), 32'd0);
    chk("rst2_count", 32'(o_count), 32'd0);
    set_req(6'b010000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    cyc();
    i_valid = 1'b0;
    check_head("rst2_lui", 32'h123452B7, 32'd0);

    // add x0,x1,x2
    set_req(6'b000001, 7'h33, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    cyc();
    i_valid = 1'b0;
`ifdef INSTR_ENC_X0_NOP_EN
    check_head("add_x0", 32'h00000013, 32'd4);
`else
    check_head("add_x0", 32'h00208033, 32'd4);
`endif
    cyc();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rand_req();
      i_ready   = ($urandom_range(0, 2) != 0);
      i_clr_err = ($urandom_range(0, 7) == 0);
      i_rst     = ($urandom_range(0, 199) == 0);
      cyc();
    end
    i_rst = 1'b0; i_valid = 1'b0; i_clr_err = 1'b0; i_ready = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
